addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/addsub_slice.sv | 26 ++
 rtl/addsub_seq.sv | 143 ++++++++++++++
 tb/tb_addsub_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// The state enum and the legacy state constants name the same encodings.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Slice index width; a single-slice configuration still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// DIGIT-bit combinational ripple adder. c_msb is the carry into the top bit,
// used by the parent to form signed overflow on the last slice.
module addsub_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, valid/ready on
// both the request and the result side.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload stable while valid is high and ready low.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_param
        $error("addsub_seq: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout, sl_cmsb;
    logic [WIDTH-1:0] s_upd;

    assign sl_a = a_q[int'(idx_q)*DIGIT +: DIGIT];
    assign sl_b = b_q[int'(idx_q)*DIGIT +: DIGIT];

    addsub_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (carry_q),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    // Result word with the current slice merged in; zero looks at this on the last slice.
    always_comb begin
        s_upd = s_q;
        s_upd[int'(idx_q)*DIGIT +: DIGIT] = sl_sum;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{mode == MODE_SUB}};
                    carry_d = (mode == MODE_SUB);
                    idx_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_d     = s_upd;
                carry_d = sl_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = sl_cout;
                    ovf_d   = sl_cmsb ^ sl_cout;
                    zero_d  = (s_upd == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed vectors on the 16/4 configuration, handshake
// corner cases, and streamed operations on both 16/4 and 8/8 configurations.
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        in_valid, in_ready, mode, out_valid, out_ready, cout, ovf, zero;
    logic [15:0] a, b, s;
    logic [1:0]  dbg_state;

    logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, s8;
    logic [1:0]  dbg_state8;

    logic [17:0] exp_q[$];

    addsub_seq #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero), .dbg_state(dbg_state)
    );

    addsub_seq #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8), .dbg_state(dbg_state8)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, s} for a w-bit add/subtract, w = 8 or 16.
    function automatic logic [17:0] ref_op(input logic [15:0] av, input logic [15:0] bv,
                                           input logic m, input int w);
        logic [16:0] full;
        logic [15:0] mask, am, bx, sv;
        logic        c, v;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        am   = av & mask;
        bx   = (bv ^ {16{m}}) & mask;
        full = {1'b0, am} + {1'b0, bx} + {16'h0, m};
        sv   = full[15:0] & mask;
        c    = full[w];
        v    = (am[w-1] == bx[w-1]) && (sv[w-1] != am[w-1]);
        return {v, c, sv};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_out16(output int lat);
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic m,
                         input logic [15:0] es, input logic ec, input logic ev,
                         input logic ez, input string tag);
        int lat;
        a = av; b = bv; mode = m; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out16(lat);
        check({tag, ".lat"}, lat, 4);
        check({tag, ".s"}, s, es);
        check({tag, ".cout"}, cout, ec);
        check({tag, ".ovf"}, ovf, ev);
        check({tag, ".zero"}, zero, ez);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        check({tag, ".out_valid"}, out_valid, 1'b0);
    endtask

    // Hand-computed directed vectors.
    logic [15:0] va[9] = '{16'h7FFF, 16'h0005, 16'h0000, 16'h8000, 16'hFFFF,
                           16'h1234, 16'h8000, 16'h0FF0, 16'h1000};
    logic [15:0] vb[9] = '{16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'h0001,
                           16'h4321, 16'h8000, 16'h0010, 16'h0001};
    logic        vm[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] vs[9] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h0000,
                           16'h5555, 16'h0000, 16'h1000, 16'h0FFF};
    logic        vc[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vv[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vz[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // ---------------- main sequence ----------------
    initial begin
        int lat, ov_cnt, t_acc;
        logic [17:0] exp;

        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; mode8 = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.s", s, 16'h0000);
        check("rst.flags", {cout, ovf, zero}, 3'b000);
        check("rst.state", dbg_state, 2'd0);
        check("rst.out_valid8", out_valid8, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors; the first is accepted on the first edge after release.
        for (int i = 0; i < 9; i++) begin
            do_op(va[i], vb[i], vm[i], vs[i], vc[i], vv[i], vz[i], $sformatf("v%0d", i));
        end

        // Backpressure: result held for three cycles while in_valid toggles.
        a = 16'h1234; b = 16'h4321; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out16(lat);
        check("bp.lat", lat, 4);
        for (int k = 0; k < 3; k++) begin
            in_valid = (k % 2 == 0);
            a = 16'($urandom_range(0, 16'hFFFF));
            b = 16'($urandom_range(0, 16'hFFFF));
            mode = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check($sformatf("bp.s%0d", k), s, 16'h5555);
            check($sformatf("bp.flags%0d", k), {cout, ovf, zero}, 3'b000);
            check($sformatf("bp.out_valid%0d", k), out_valid, 1'b1);
            check($sformatf("bp.in_ready%0d", k), in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.in_ready_after", in_ready, 1'b1);
        check("bp.out_valid_after", out_valid, 1'b0);

        // Reset during the second BUSY cycle.
        a = 16'h1111; b = 16'h2222; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("ra.out_valid", out_valid, 1'b0);
        check("ra.in_ready", in_ready, 1'b1);
        check("ra.s", s, 16'h0000);
        check("ra.flags", {cout, ovf, zero}, 3'b000);
        check("ra.state", dbg_state, 2'd0);
        @(negedge clk) rst_n = 1'b1;
        ov_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        check("ra.no_result", ov_cnt, 0);
        do_op(16'h0FF0, 16'h0010, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "ra.next");

        // Streamed operations, 16/4: one result every N+2 = 6 cycles.
        in_valid = 1'b1; out_ready = 1'b1;
        t_acc = 0;
        for (int op = 0; op < 10; op++) begin
            a = 16'($urandom_range(0, 16'hFFFF));
            b = 16'($urandom_range(0, 16'hFFFF));
            mode = 1'($urandom_range(0, 1));
            exp_q.push_back(ref_op(a, b, mode, 16));
            @(posedge clk); #1;
            if (op > 0) check($sformatf("st16.period%0d", op), cyc - t_acc, 6);
            t_acc = cyc;
            wait_out16(lat);
            check($sformatf("st16.lat%0d", op), lat, 4);
            exp = exp_q.pop_front();
            check($sformatf("st16.res%0d", op), {ovf, cout, s}, exp);
            check($sformatf("st16.zero%0d", op), zero, exp[15:0] == 16'h0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Streamed operations, 8/8: single BUSY cycle, one result every 3 cycles.
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        t_acc = 0;
        for (int op = 0; op < 10; op++) begin
            a8 = 8'($urandom_range(0, 8'hFF));
            b8 = 8'($urandom_range(0, 8'hFF));
            if (op == 0) begin
                a8 = 8'h7F; b8 = 8'h01;
            end
            mode8 = (op == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            exp_q.push_back(ref_op({8'h00, a8}, {8'h00, b8}, mode8, 8));
            @(posedge clk); #1;
            if (op > 0) check($sformatf("st8.period%0d", op), cyc - t_acc, 3);
            t_acc = cyc;
            lat = 0;
            while (!out_valid8 && lat < 12) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("st8.lat%0d", op), lat, 1);
            exp = exp_q.pop_front();
            check($sformatf("st8.res%0d", op), {ovf8, cout8, 8'h00, s8}, exp);
            check($sformatf("st8.zero%0d", op), zero8, exp[7:0] == 8'h0);
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
